// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: shared state encoding and averaging limits for the ADC conversion scheduler
package adc_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SAMPLE, CONVERT, OUTPUT, WAIT_PERIOD} state_e;
  localparam int AVG_LOG2_MAX = 4;
  function automatic logic [2:0] clamp_avg(input logic [2:0] n);
    return (n > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : n;
  endfunction
endpackage

// File: rtl/adc_sync_edge.sv
// adc_sync_edge: synchronises an async level into clk and emits a one-cycle rising-edge pulse
//   clk, rst_n : clock, async active-low reset
//   d_async    : asynchronous input level
//   rise       : one-cycle pulse on each synchronised rising edge
module adc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_async};
    prev_d = sync_q[STAGES-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign rise = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: timed SAR conversion sequencer with 2^n averaging and a valid/ready result port
//   cfg_*            : burst configuration, captured when a burst starts
//   trig             : single-shot request; conv_done_async/adc_data from the SAR
//   start_conv/ena_in: edge-detect start and clkgen enable
//   res_valid/res_ready/res_data : averaged result handshake
//   busy, err_timeout: status (err_timeout sticky until err_clr)
module adc_conv_scheduler
  import adc_ctrl_pkg::*;
#(
  parameter int RES_BITS    = 12,
  parameter int TMR_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_ena,
  input  logic                cfg_continuous,
  input  logic [TMR_W-1:0]    cfg_sample_cycles,
  input  logic [TMR_W-1:0]    cfg_period,
  input  logic [TMR_W-1:0]    cfg_timeout,
  input  logic [2:0]          cfg_avg_log2,
  input  logic                trig,
  input  logic                err_clr,
  input  logic                conv_done_async,
  input  logic [RES_BITS-1:0] adc_data,
  output logic                start_conv,
  output logic                ena_in,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RES_BITS-1:0] res_data,
  output logic                err_timeout
);
  localparam int ACC_W = RES_BITS + AVG_LOG2_MAX;
  state_e state_q, state_d;
  logic start_q, start_d, ena_q, ena_d, valid_q, valid_d, err_q, err_d, cont_q, cont_d;
  logic [RES_BITS-1:0] data_q, data_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] n_q, n_d;
  logic [TMR_W-1:0] smp_q, smp_d, cv_q, cv_d, per_q, per_d;
  logic [TMR_W-1:0] smp_lim_q, smp_lim_d, period_q, period_d, tmo_q, tmo_d;
  logic [TMR_W:0] per_inc;
  logic done, elapsed, new_burst, next_sample, abort;

  adc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .d_async(conv_done_async), .rise(done)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    ena_d       = ena_q;
    valid_d     = valid_q;
    data_d      = data_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    smp_d       = smp_q;
    cv_d        = cv_q;
    err_d       = err_q & ~err_clr;
    new_burst   = 1'b0;
    next_sample = 1'b0;
    abort       = 1'b0;
    sum         = acc_q + {{AVG_LOG2_MAX{1'b0}}, adc_data};
    // period timer measures start-to-start and saturates so a long stall still reads as elapsed
    per_d       = (per_q == '1) ? per_q : per_q + TMR_W'(1);
    per_inc     = {1'b0, per_q} + (TMR_W+1)'(1);
    elapsed     = per_inc >= {1'b0, period_q};
    case (state_q)
      IDLE: new_burst = cfg_ena & (trig | cfg_continuous);
      SAMPLE: begin
        if (!cfg_ena) abort = 1'b1;
        else if (smp_q == smp_lim_q) begin
          state_d = CONVERT;
          start_d = 1'b0;
          ena_d   = 1'b1;
          cv_d    = '0;
        end else smp_d = smp_q + TMR_W'(1);
      end
      CONVERT: begin
        if (!cfg_ena) abort = 1'b1;
        else if (done) begin
          ena_d = 1'b0;
          if (cnt_q + 5'd1 < (5'd1 << n_q)) begin
            acc_d       = sum;
            cnt_d       = cnt_q + 5'd1;
            next_sample = 1'b1;
          end else begin
            state_d = OUTPUT;
            valid_d = 1'b1;
            data_d  = RES_BITS'(sum >> n_q);
            acc_d   = '0;
            cnt_d   = '0;
          end
        end else if (tmo_q != '0 && cv_q + TMR_W'(1) == tmo_q) begin
          state_d = IDLE;
          ena_d   = 1'b0;
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end else cv_d = cv_q + TMR_W'(1);
      end
      OUTPUT: begin
        if (res_ready) begin
          valid_d = 1'b0;
          if (cont_q & cfg_ena) begin
            new_burst = elapsed;
            state_d   = elapsed ? state_q : WAIT_PERIOD;
          end else state_d = IDLE;
        end
      end
      WAIT_PERIOD: begin
        if (!cfg_ena) abort = 1'b1;
        else new_burst = elapsed;
      end
      default: state_d = IDLE;
    endcase
    if (next_sample | new_burst) begin
      state_d = SAMPLE;
      start_d = 1'b1;
      smp_d   = '0;
    end
    if (new_burst) per_d = '0;
    if (abort) begin
      state_d = IDLE;
      start_d = 1'b0;
      ena_d   = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
    end
    cont_d    = new_burst ? cfg_continuous : cont_q;
    n_d       = new_burst ? clamp_avg(cfg_avg_log2) : n_q;
    smp_lim_d = new_burst ? ((cfg_sample_cycles == '0) ? '0 : cfg_sample_cycles - TMR_W'(1)) : smp_lim_q;
    period_d  = new_burst ? cfg_period : period_q;
    tmo_d     = new_burst ? cfg_timeout : tmo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      ena_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cont_q    <= 1'b0;
      data_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      smp_q     <= '0;
      cv_q      <= '0;
      per_q     <= '0;
      smp_lim_q <= '0;
      period_q  <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      ena_q     <= ena_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      cont_q    <= cont_d;
      data_q    <= data_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      smp_q     <= smp_d;
      cv_q      <= cv_d;
      per_q     <= per_d;
      smp_lim_q <= smp_lim_d;
      period_q  <= period_d;
      tmo_q     <= tmo_d;
    end
  end

  assign start_conv  = start_q;
  assign ena_in      = ena_q;
  assign busy        = state_q != IDLE;
  assign res_valid   = valid_q;
  assign res_data    = data_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// tb_adc_conv_scheduler: directed self-checking bench for adc_conv_scheduler with a SAR model
module tb_adc_conv_scheduler;
  localparam int RB = 12;
  localparam int TW = 16;
  logic clk = 1'b0, rst_n = 1'b0, cfg_ena = 1'b0, cfg_continuous = 1'b0;
  logic trig = 1'b0, err_clr = 1'b0, conv_done_async = 1'b0, res_ready = 1'b0;
  logic [TW-1:0] cfg_sample_cycles = 16'd10, cfg_period = '0, cfg_timeout = '0;
  logic [2:0] cfg_avg_log2 = '0;
  logic [RB-1:0] adc_data = '0;
  logic start_conv, ena_in, busy, res_valid, err_timeout;
  logic [RB-1:0] res_data;
  int checks = 0, failures = 0;
  logic sar_en = 1'b0;
  logic [RB-1:0] sar_vals [16];
  int sar_idx = 0, sar_fired = 0, rises = 0, accepted = 0;
  time rise_t [128];

  always #5 clk = ~clk;

  adc_conv_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cfg_ena(cfg_ena), .cfg_continuous(cfg_continuous),
    .cfg_sample_cycles(cfg_sample_cycles), .cfg_period(cfg_period), .cfg_timeout(cfg_timeout),
    .cfg_avg_log2(cfg_avg_log2), .trig(trig), .err_clr(err_clr),
    .conv_done_async(conv_done_async), .adc_data(adc_data), .start_conv(start_conv),
    .ena_in(ena_in), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .err_timeout(err_timeout)
  );

  // SAR model: done rises 50 cycles after start_conv falls, off the clock edge
  always @(negedge start_conv) begin
    if (sar_en) begin
      repeat (50) @(posedge clk);
      #2;
      adc_data = sar_vals[sar_idx % 16];
      sar_idx++;
      sar_fired++;
      conv_done_async = 1'b1;
      repeat (6) @(posedge clk);
      #2 conv_done_async = 1'b0;
    end
  end

  always @(posedge start_conv) begin
    if (rises < 128) rise_t[rises] = $time;
    rises++;
  end

  always @(posedge clk) if (res_valid === 1'b1 && res_ready === 1'b1) accepted++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && res_valid !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic wait_ena(input logic lvl, input int budget);
    for (int i = 0; i < budget && ena_in !== lvl; i++) @(negedge clk);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    int hi, r0, r1, f0, a0;
    for (int i = 0; i < 16; i++) sar_vals[i] = '0;
    cyc(2);
    check("rst_start", 32'(start_conv), 32'd0);
    check("rst_ena", 32'(ena_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data_err", {19'd0, err_timeout, res_data}, 32'd0);
    rst_n = 1'b1;
    cfg_ena = 1'b1;
    sar_en = 1'b1;
    cyc(2);
    // 1: single sample, pulse width and held result
    sar_vals[0] = 12'hA5C;
    sar_idx = 0;
    pulse_trig();
    check("t1_rise", 32'(start_conv), 32'd1);
    hi = 0;
    while (start_conv === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("t1_width", 32'(hi), 32'd10);
    check("t1_ena", 32'(ena_in), 32'd1);
    wait_valid(200);
    check("t1_valid", 32'(res_valid), 32'd1);
    check("t1_data", 32'(res_data), 32'hA5C);
    check("t1_ena_off", 32'(ena_in), 32'd0);
    cyc(5);
    check("t1_hold_valid", 32'(res_valid), 32'd1);
    check("t1_hold_data", 32'(res_data), 32'hA5C);
    accept();
    check("t1_acc_valid", 32'(res_valid), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    // 2: four-sample average
    cfg_avg_log2 = 3'd2;
    sar_vals[0] = 12'd100; sar_vals[1] = 12'd101; sar_vals[2] = 12'd102; sar_vals[3] = 12'd105;
    sar_idx = 0;
    r0 = rises;
    pulse_trig();
    wait_valid(1000);
    check("t2_valid", 32'(res_valid), 32'd1);
    check("t2_data", 32'(res_data), 32'd102);
    check("t2_pulses", 32'(rises - r0), 32'd4);
    accept();
    // 3: timeout without done
    sar_en = 1'b0;
    cfg_avg_log2 = 3'd0;
    cfg_timeout = 16'd20;
    pulse_trig();
    wait_ena(1'b1, 50);
    check("t3_conv", 32'(ena_in), 32'd1);
    hi = 0;
    while (ena_in === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("t3_len", 32'(hi), 32'd20);
    check("t3_err", 32'(err_timeout), 32'd1);
    check("t3_novalid", 32'(res_valid), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);
    cyc(3);
    check("t3_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t3_clr", 32'(err_timeout), 32'd0);
    cfg_timeout = '0;
    sar_en = 1'b1;
    // 4: continuous period and backpressure
    for (int i = 0; i < 16; i++) sar_vals[i] = 12'h123;
    cfg_period = 16'd200;
    res_ready = 1'b1;
    r0 = rises;
    cfg_continuous = 1'b1;
    for (int i = 0; i < 1000 && rises < r0 + 3; i++) @(negedge clk);
    check("t4_rises", 32'(rises - r0 >= 3), 32'd1);
    check("t4_per1", 32'(rise_t[r0+1] - rise_t[r0]), 32'd2000);
    check("t4_per2", 32'(rise_t[r0+2] - rise_t[r0+1]), 32'd2000);
    res_ready = 1'b0;
    wait_valid(400);
    check("t4_bp_valid", 32'(res_valid), 32'd1);
    f0 = sar_fired;
    r1 = rises;
    cyc(500);
    check("t4_bp_hold", 32'(res_valid), 32'd1);
    check("t4_bp_data", 32'(res_data), 32'h123);
    check("t4_bp_nostart", 32'(rises), 32'(r1));
    check("t4_bp_nosar", 32'(sar_fired), 32'(f0));
    a0 = accepted;
    res_ready = 1'b1;
    @(negedge clk);
    check("t4_direct", 32'(start_conv), 32'd1);
    check("t4_acc_valid", 32'(res_valid), 32'd0);
    check("t4_acc_cnt", 32'(accepted), 32'(a0 + 1));
    cfg_ena = 1'b0;
    cfg_continuous = 1'b0;
    @(negedge clk);
    check("t4_stop_busy", 32'(busy), 32'd0);
    check("t4_stop_start", 32'(start_conv), 32'd0);
    cyc(100);
    res_ready = 1'b0;
    cfg_ena = 1'b1;
    cfg_period = '0;
    // 5: clamped 16-sample average at full scale
    for (int i = 0; i < 16; i++) sar_vals[i] = 12'hFFF;
    cfg_avg_log2 = 3'd7;
    sar_idx = 0;
    r0 = rises;
    pulse_trig();
    wait_valid(3000);
    check("t5_valid", 32'(res_valid), 32'd1);
    check("t5_data", 32'(res_data), 32'hFFF);
    check("t5_pulses", 32'(rises - r0), 32'd16);
    accept();
    // 6a: async reset mid-CONVERT
    cfg_avg_log2 = 3'd0;
    sar_vals[0] = 12'h555;
    sar_idx = 0;
    pulse_trig();
    wait_ena(1'b1, 50);
    cyc(10);
    rst_n = 1'b0;
    #1;
    check("t6_rst_start", 32'(start_conv), 32'd0);
    check("t6_rst_ena", 32'(ena_in), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(100);
    check("t6_rst_novalid", 32'(res_valid), 32'd0);
    // 6b: cfg_ena drop in the second CONVERT of a two-sample burst
    cfg_avg_log2 = 3'd1;
    sar_vals[0] = 12'h100; sar_vals[1] = 12'h200;
    sar_idx = 0;
    pulse_trig();
    wait_ena(1'b1, 50);
    wait_ena(1'b0, 200);
    wait_ena(1'b1, 50);
    cyc(5);
    cfg_ena = 1'b0;
    @(negedge clk);
    check("t6_ab_ena", 32'(ena_in), 32'd0);
    check("t6_ab_start", 32'(start_conv), 32'd0);
    check("t6_ab_busy", 32'(busy), 32'd0);
    cfg_ena = 1'b1;
    cyc(100);
    check("t6_ab_novalid", 32'(res_valid), 32'd0);
    // 6c: next burst starts from a cleared accumulator
    cfg_avg_log2 = 3'd0;
    sar_vals[0] = 12'h3C3;
    sar_idx = 0;
    pulse_trig();
    wait_valid(300);
    check("t6_next_valid", 32'(res_valid), 32'd1);
    check("t6_next_data", 32'(res_data), 32'h3C3);
    accept();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
